// File: rtl/tube_pkg.sv
// Shared constants for seven-segment tube display blocks: glyph codes,
// scheduler state encoding and bank geometry.
package tube_pkg;

  localparam int DIGITS = 8;

  typedef logic [3:0] nibble_t;

  // Segment order {a,b,c,d,e,f,g,dp}, active-high, dp never lit
  localparam logic [7:0] SEG_0     = 8'hFC;
  localparam logic [7:0] SEG_1     = 8'h60;
  localparam logic [7:0] SEG_2     = 8'hDA;
  localparam logic [7:0] SEG_3     = 8'hF2;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'hB6;
  localparam logic [7:0] SEG_6     = 8'hBE;
  localparam logic [7:0] SEG_7     = 8'hE0;
  localparam logic [7:0] SEG_8     = 8'hFE;
  localparam logic [7:0] SEG_9     = 8'hF6;
  localparam logic [7:0] SEG_A     = 8'hEE;
  localparam logic [7:0] SEG_B     = 8'h3E;
  localparam logic [7:0] SEG_C     = 8'h9C;
  localparam logic [7:0] SEG_D     = 8'h7A;
  localparam logic [7:0] SEG_E     = 8'h9E;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam logic [1:0] ST_BLANK        = 2'd0;
  localparam logic [1:0] ST_SHOW_MILEAGE = 2'd1;
  localparam logic [1:0] ST_SHOW_MSG     = 2'd2;

endpackage

// File: rtl/tube_display_scheduler_if.sv
// Requester-side and tube-pin signals of the display scheduler; master is the
// requester/board side, slave is the scheduler.
interface tube_display_scheduler_if;
  import tube_pkg::*;

  logic                  mileage_en;
  logic [4*DIGITS-1:0]   mileage_bcd;
  logic                  msg_req;
  logic [4*DIGITS-1:0]   msg_data;
  logic                  msg_ack;
  logic                  msg_active;
  logic [DIGITS-1:0]     tube_sel;
  logic [7:0]            tube_seg;

  modport master (
    output mileage_en, mileage_bcd, msg_req, msg_data,
    input  msg_ack, msg_active, tube_sel, tube_seg
  );

  modport slave (
    input  mileage_en, mileage_bcd, msg_req, msg_data,
    output msg_ack, msg_active, tube_sel, tube_seg
  );

endinterface

// File: rtl/tube_seg_decoder.sv
// Combinational nibble -> seven-segment code; 0xF is the blank glyph.
module tube_seg_decoder
  import tube_pkg::*;
(
  input  nibble_t    nibble,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/tube_display_scheduler.sv
// Scans the 8-digit tube bank and arbitrates it between mileage and messages.
//   state           | meaning
//   ST_BLANK        | nobody owns the display, frames load all-blank
//   ST_SHOW_MILEAGE | frames load mileage_bcd with leading-zero suppression
//   ST_SHOW_MSG     | frames load the message latch until the hold expires
module tube_display_scheduler
  import tube_pkg::*;
#(
  parameter int SCAN_DIV   = 100000,
  parameter int HOLD_TICKS = 2000
) (
  input logic                     clk,
  input logic                     rst,
  tube_display_scheduler_if.slave bus
);

  localparam int PRE_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

  logic [PRE_W-1:0]    pre;
  logic [2:0]          idx;
  logic [2:0]          idx_nxt;
  logic [1:0]          state;
  logic [HOLD_W-1:0]   hold;
  logic [4*DIGITS-1:0] frame;
  logic [4*DIGITS-1:0] frame_nxt;
  logic [4*DIGITS-1:0] msg_latch;
  logic [4*DIGITS-1:0] mileage_sup;
  logic                tick;
  logic                boundary;
  logic                accept;
  logic                lead;
  nibble_t             nib_nxt;
  logic [7:0]          seg_nxt;

  assign tick     = (pre == PRE_W'(SCAN_DIV - 1));
  assign boundary = tick && (idx == 3'd7);
  assign idx_nxt  = idx + 3'd1;
  assign accept   = bus.msg_req && !bus.msg_ack;

  assign bus.msg_active = (state == ST_SHOW_MSG);

  // Blank zeros from the top down until the first significant digit
  always_comb begin
    mileage_sup = bus.mileage_bcd;
    lead        = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (bus.mileage_bcd[4*i +: 4] == 4'h0))
        mileage_sup[4*i +: 4] = 4'hF;
      else
        lead = 1'b0;
    end
  end

  always_comb begin
    frame_nxt = frame;
    if (boundary) begin
      case (state)
        ST_SHOW_MSG:     frame_nxt = msg_latch;
        ST_SHOW_MILEAGE: frame_nxt = mileage_sup;
        default:         frame_nxt = '1;
      endcase
    end
  end

  // The output register samples the frame as it will be after this edge,
  // so digit 0 of a freshly loaded frame shows without a one-tick lag.
  assign nib_nxt = frame_nxt[4*idx_nxt +: 4];

  tube_seg_decoder u_decoder (
    .nibble (nib_nxt),
    .seg    (seg_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre          <= '0;
      idx          <= '0;
      hold         <= '0;
      frame        <= '1;
      msg_latch    <= '0;
      state        <= ST_BLANK;
      bus.msg_ack  <= 1'b0;
      bus.tube_sel <= '0;
      bus.tube_seg <= '0;
    end else begin
      pre         <= tick ? '0 : pre + PRE_W'(1);
      frame       <= frame_nxt;
      bus.msg_ack <= accept;
      if (tick) begin
        idx          <= idx_nxt;
        bus.tube_sel <= DIGITS'(1) << idx_nxt;
        bus.tube_seg <= seg_nxt;
      end
      if (accept) begin
        msg_latch <= bus.msg_data;
        hold      <= HOLD_W'(HOLD_TICKS);
        state     <= ST_SHOW_MSG;
      end else begin
        case (state)
          ST_BLANK:
            if (bus.mileage_en) state <= ST_SHOW_MILEAGE;
          ST_SHOW_MILEAGE:
            if (!bus.mileage_en) state <= ST_BLANK;
          ST_SHOW_MSG:
            if (tick) begin
              hold <= hold - HOLD_W'(1);
              if (hold == HOLD_W'(1))
                state <= bus.mileage_en ? ST_SHOW_MILEAGE : ST_BLANK;
            end
          default:
            state <= ST_BLANK;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tube_display_scheduler.sv
// Bench for tube_display_scheduler: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the display.
module tb_tube_display_scheduler;

  localparam int SCAN_DIV   = 4;
  localparam int HOLD_TICKS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tube_display_scheduler_if b ();

  tube_display_scheduler #(
    .SCAN_DIV   (SCAN_DIV),
    .HOLD_TICKS (HOLD_TICKS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit auto_req = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Behavioural model: time in whole cycles and scan ticks since reset
  logic [7:0] glyph [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                             8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h00};
  localparam int OWN_NONE = 0, OWN_MILEAGE = 1, OWN_MSG = 2;

  int          m_cycles, m_ticks, m_owner, m_hold;
  bit          m_ack;
  int          m_frame [8];
  logic [31:0] m_latch;
  logic [7:0]  e_sel, e_seg;
  bit          m_tick, m_accept;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cycles = 0; m_ticks = 0; m_owner = OWN_NONE; m_hold = 0; m_ack = 0;
      m_latch = 0; e_sel = 0; e_seg = 0;
      for (int i = 0; i < 8; i++) m_frame[i] = 15;
    end else begin
      m_tick   = ((m_cycles + 1) % SCAN_DIV) == 0;
      m_accept = b.msg_req && !m_ack;
      if (m_tick && (m_ticks % 8) == 7) begin
        for (int i = 0; i < 8; i++) begin
          if (m_owner == OWN_MSG)
            m_frame[i] = int'((m_latch >> (4*i)) & 32'hF);
          else if (m_owner == OWN_MILEAGE)
            m_frame[i] = (i > 0 && (b.mileage_bcd >> (4*i)) == 0) ? 15
                         : int'((b.mileage_bcd >> (4*i)) & 32'hF);
          else
            m_frame[i] = 15;
        end
      end
      if (m_tick) begin
        m_ticks++;
        e_sel = 8'(1) << (m_ticks % 8);
        e_seg = glyph[m_frame[m_ticks % 8]];
      end
      m_ack = m_accept;
      if (m_accept) begin
        m_owner = OWN_MSG; m_hold = HOLD_TICKS; m_latch = b.msg_data;
      end else if (m_owner == OWN_MSG) begin
        if (m_tick) begin
          m_hold--;
          if (m_hold == 0) m_owner = b.mileage_en ? OWN_MILEAGE : OWN_NONE;
        end
      end else begin
        m_owner = b.mileage_en ? OWN_MILEAGE : OWN_NONE;
      end
      m_cycles++;
    end
  end

  function automatic logic [31:0] rand_bcd();
    logic [31:0] v = 0;
    int k = $urandom_range(0, 8);
    for (int i = 0; i < k; i++)
      v[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                : 4'($urandom_range(0, 9));
    return v;
  endfunction

  task automatic step();
    @(negedge clk);
    check("sel",    32'(b.tube_sel),   32'(e_sel));
    check("seg",    32'(b.tube_seg),   32'(e_seg));
    check("ack",    32'(b.msg_ack),    32'(m_ack));
    check("active", 32'(b.msg_active), 32'(m_owner == OWN_MSG));
    if (b.msg_req && b.msg_ack) begin
      if (auto_req && $urandom_range(0, 4) == 0) b.msg_data = $urandom();
      else b.msg_req = 1'b0;
    end else if (auto_req && !b.msg_req && $urandom_range(0, 99) < 4) begin
      b.msg_req  = 1'b1;
      b.msg_data = $urandom();
    end
    if (auto_req) begin
      if ($urandom_range(0, 99) == 0) b.mileage_en = ~b.mileage_en;
      if ($urandom_range(0, 49) == 0) b.mileage_bcd = rand_bcd();
    end
  endtask

  task automatic send_msg(input logic [31:0] data);
    int waited = 0;
    b.msg_req  = 1'b1;
    b.msg_data = data;
    while (b.msg_req && waited < 5) begin
      step();
      waited++;
    end
    check("ack_wait", 32'(b.msg_req), 32'd0);
  endtask

  initial begin
    int found;
    b.mileage_en  = 1'b1;
    b.mileage_bcd = 32'h0000_1205;
    b.msg_req     = 1'b0;
    b.msg_data    = '0;
    repeat (2) @(negedge clk);
    check("rst_sel",    32'(b.tube_sel),   32'd0);
    check("rst_seg",    32'(b.tube_seg),   32'd0);
    check("rst_ack",    32'(b.msg_ack),    32'd0);
    check("rst_active", 32'(b.msg_active), 32'd0);
    rst = 1'b0;

    repeat (100) step();
    b.mileage_bcd = 32'h0000_0000;
    repeat (70) step();
    b.mileage_bcd = 32'h0000_1205;
    repeat (40) step();

    send_msg(32'hFFFF_E0D0);
    repeat (6) step();
    send_msg(32'hFFFF_1234);
    repeat (70) step();

    // Raise a request on the very cycle the hold would expire
    send_msg(32'hFFFF_ABCD);
    found = 0;
    for (int n = 0; n < 200 && found == 0; n++) begin
      if (m_owner == OWN_MSG && m_hold == 1 && !m_ack &&
          ((m_cycles + 1) % SCAN_DIV) == 0) found = 1;
      else step();
    end
    check("collide_wait", 32'(found), 32'd1);
    b.msg_req  = 1'b1;
    b.msg_data = 32'hFFFF_5678;
    step();
    check("collide_active", 32'(b.msg_active), 32'd1);
    repeat (60) step();

    b.mileage_en = 1'b0;
    repeat (80) step();
    b.mileage_en = 1'b1;
    repeat (40) step();

    // Async reset between edges with a request pending
    send_msg(32'hFFFF_0E0E);
    repeat (5) step();
    b.msg_req  = 1'b1;
    b.msg_data = 32'hFFFF_9999;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_sel",    32'(b.tube_sel),   32'd0);
    check("arst_seg",    32'(b.tube_seg),   32'd0);
    check("arst_ack",    32'(b.msg_ack),    32'd0);
    check("arst_active", 32'(b.msg_active), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("arst_reack", 32'(b.msg_ack), 32'd1);
    repeat (60) step();

    auto_req = 1;
    repeat (2500) step();
    auto_req = 0;
    b.msg_req = 1'b0;
    repeat (10) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
